// File: rtl/jacobi_5pt_stream.sv
// jacobi_5pt_stream: streaming 5-point Jacobi Laplace solver on a ROWS x COLS
// interior grid with a fixed one-cell boundary ring, signed Q(WIDTH-FRAC).FRAC.
// Optional build macro JACOBI_DAMP_EN adds a damped update using an omega input.
module jacobi_5pt_stream #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int WIDTH  = 32,
  parameter int FRAC   = 16,
  parameter int ITER_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  tol,
  input  logic [ITER_W-1:0] max_iter,
`ifdef JACOBI_DAMP_EN
  input  logic [WIDTH-1:0]  omega,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [ITER_W-1:0] iter_count
);

  localparam int N  = (ROWS + 2) * (COLS + 2);
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] STRIDE = AW'(COLS + 2);
  localparam logic [AW-1:0] FIRST  = AW'(COLS + 3);
  localparam logic [AW-1:0] LAST   = AW'(N - 1);

  if (FRAC >= WIDTH) begin : g_bad_frac
    $error("FRAC must be smaller than WIDTH");
  end

  typedef enum logic [2:0] {IDLE, LOAD, SWEEP, CHECK, UNLOAD} state_t;

  state_t state, state_n;

  logic [WIDTH-1:0]  mem_a [N];
  logic [WIDTH-1:0]  mem_b [N];
  logic              src_b;
  logic [AW-1:0]     cnt, pt_addr, row, col;
  logic [WIDTH+2:0]  maxres;
  logic [WIDTH-1:0]  tol_q;
  logic [ITER_W-1:0] max_iter_q, iter_next;
  logic              pt_last, sweep_live, sweep_end, res_ok, accept_start;
  logic [WIDTH-1:0]  u_c, u_n, u_s, u_w, u_e, avg;
  logic signed [WIDTH+1:0] s;
  logic signed [WIDTH+2:0] r;
  logic [WIDTH+2:0]  r_abs;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [WIDTH-1:0]  wr_data;

`ifdef JACOBI_DAMP_EN
  logic [WIDTH-1:0]  omega_q;
  logic              drain, d_valid;
  logic [AW-1:0]     d_addr;
  logic [WIDTH-1:0]  d_avg, d_u;
  logic signed [WIDTH:0]     diff;
  logic signed [2*WIDTH+1:0] prod, upd;
`endif

  // Stencil arithmetic on the current source buffer: neighbour sum, average, residual.
  always_comb begin
    u_c   = src_b ? mem_b[pt_addr]          : mem_a[pt_addr];
    u_n   = src_b ? mem_b[pt_addr - STRIDE] : mem_a[pt_addr - STRIDE];
    u_s   = src_b ? mem_b[pt_addr + STRIDE] : mem_a[pt_addr + STRIDE];
    u_w   = src_b ? mem_b[pt_addr - 1'b1]   : mem_a[pt_addr - 1'b1];
    u_e   = src_b ? mem_b[pt_addr + 1'b1]   : mem_a[pt_addr + 1'b1];
    s     = $signed({{2{u_n[WIDTH-1]}}, u_n}) + $signed({{2{u_s[WIDTH-1]}}, u_s})
          + $signed({{2{u_w[WIDTH-1]}}, u_w}) + $signed({{2{u_e[WIDTH-1]}}, u_e});
    avg   = s[WIDTH+1:2];
    r     = $signed({u_c[WIDTH-1], u_c, 2'b00}) - $signed({s[WIDTH+1], s});
    r_abs = r[WIDTH+2] ? 0 - r : r;
    pt_last   = (row == AW'(ROWS)) && (col == AW'(COLS));
    res_ok    = maxres <= {3'b000, tol_q};
    iter_next = iter_count + ITER_W'(1);
    accept_start = start && !done;
`ifdef JACOBI_DAMP_EN
    sweep_live = (state == SWEEP) && !drain;
    sweep_end  = drain;
    diff  = $signed({d_avg[WIDTH-1], d_avg}) - $signed({d_u[WIDTH-1], d_u});
    prod  = $signed({{(WIDTH+1){diff[WIDTH]}}, diff})
          * $signed({{(WIDTH+2){omega_q[WIDTH-1]}}, omega_q});
    upd   = (prod >>> FRAC) + $signed({{(WIDTH+2){d_u[WIDTH-1]}}, d_u});
    wr_en   = d_valid;
    wr_addr = d_addr;
    if ((upd[2*WIDTH+1:WIDTH-1] == '0) || (upd[2*WIDTH+1:WIDTH-1] == '1))
      wr_data = upd[WIDTH-1:0];
    else
      wr_data = upd[2*WIDTH+1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
    sweep_live = (state == SWEEP);
    sweep_end  = pt_last;
    wr_en   = sweep_live;
    wr_addr = pt_addr;
    wr_data = avg;
`endif
  end

  // Grid storage: loads go to both buffers, sweep results go to the non-source buffer.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) begin
      mem_a[cnt] <= in_data;
      mem_b[cnt] <= in_data;
    end else if (wr_en) begin
      if (src_b) mem_a[wr_addr] <= wr_data;
      else       mem_b[wr_addr] <= wr_data;
    end
  end

`ifdef JACOBI_DAMP_EN
  // Extra pipeline stage for the damped update, plus a drain cycle at sweep end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      omega_q <= '0;
      drain   <= 1'b0;
      d_valid <= 1'b0;
      d_addr  <= '0;
      d_avg   <= '0;
      d_u     <= '0;
    end else begin
      if (state == IDLE && accept_start) omega_q <= omega;
      drain   <= (state == SWEEP) && pt_last && !drain;
      d_valid <= sweep_live;
      d_addr  <= pt_addr;
      d_avg   <= avg;
      d_u     <= u_c;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (accept_start) state_n = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && cnt == LAST)
          state_n = (max_iter_q == '0) ? UNLOAD : SWEEP;
      end
      SWEEP: if (sweep_end) state_n = CHECK;
      CHECK: begin
        if (res_ok || iter_next == max_iter_q) state_n = UNLOAD;
        else                                   state_n = SWEEP;
      end
      UNLOAD: begin
        out_valid = 1'b1;
        out_last  = (cnt == LAST);
        out_data  = src_b ? mem_b[cnt] : mem_a[cnt];
        if (out_ready && cnt == LAST) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Counters, residual tracking, buffer swap and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      pt_addr    <= '0;
      row        <= '0;
      col        <= '0;
      src_b      <= 1'b0;
      maxres     <= '0;
      tol_q      <= '0;
      max_iter_q <= '0;
      iter_count <= '0;
      converged  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept_start) begin
          tol_q      <= tol;
          max_iter_q <= max_iter;
          iter_count <= '0;
          converged  <= 1'b0;
          cnt        <= '0;
          src_b      <= 1'b0;
        end
        LOAD: if (in_valid) begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt     <= '0;
            row     <= AW'(1);
            col     <= AW'(1);
            pt_addr <= FIRST;
            maxres  <= '0;
          end
        end
        SWEEP: begin
          if (sweep_live && r_abs > maxres) maxres <= r_abs;
          if (!pt_last) begin
            if (col == AW'(COLS)) begin
              col     <= AW'(1);
              row     <= row + 1'b1;
              pt_addr <= pt_addr + AW'(3);
            end else begin
              col     <= col + 1'b1;
              pt_addr <= pt_addr + 1'b1;
            end
          end
        end
        CHECK: begin
          iter_count <= iter_next;
          src_b      <= ~src_b;
          converged  <= res_ok;
          cnt        <= '0;
          row        <= AW'(1);
          col        <= AW'(1);
          pt_addr    <= FIRST;
          maxres     <= '0;
        end
        UNLOAD: if (out_ready) begin
          if (cnt == LAST) begin
            cnt  <= '0;
            done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jacobi_5pt_stream.sv
// tb_jacobi_5pt_stream: self-checking bench for jacobi_5pt_stream (default build).
module tb_jacobi_5pt_stream;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int WIDTH  = 32;
  localparam int FRAC   = 16;
  localparam int ITER_W = 16;
  localparam int N      = (ROWS + 2) * (COLS + 2);
  localparam int STRIDE = COLS + 2;

  typedef logic [WIDTH-1:0] grid_t [N];

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [WIDTH-1:0]  tol = '0;
  logic [ITER_W-1:0] max_iter = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              converged;
  logic [ITER_W-1:0] iter_count;

  int n_cmp  = 0;
  int n_fail = 0;

  grid_t got;
  int    got_iter, got_dones, got_lat, got_beats;
  bit    got_conv, got_stall_ok, got_last_ok, got_busy_after;

  jacobi_5pt_stream #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH), .FRAC(FRAC), .ITER_W(ITER_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tol(tol), .max_iter(max_iter),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .converged(converged), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  // Reference: repeated Jacobi sweeps on whole-grid integer arrays with floor division.
  task automatic model(input grid_t g, input logic [WIDTH-1:0] tol_v, input int mi,
                       output grid_t res, output int it, output bit conv);
    longint cur [N];
    longint nxt [N];
    longint s, r, mr;
    for (int k = 0; k < N; k++) cur[k] = longint'($signed(g[k]));
    it = 0;
    conv = 0;
    while (it < mi && !conv) begin
      mr = 0;
      nxt = cur;
      for (int i = 1; i <= ROWS; i++) begin
        for (int j = 1; j <= COLS; j++) begin
          int c;
          c = i * STRIDE + j;
          s = cur[c-STRIDE] + cur[c+STRIDE] + cur[c-1] + cur[c+1];
          nxt[c] = (s >= 0) ? s / 4 : -((-s + 3) / 4);
          r = 4 * cur[c] - s;
          if (r < 0) r = -r;
          if (r > mr) mr = r;
        end
      end
      cur = nxt;
      it++;
      if (mr <= longint'(tol_v)) conv = 1;
    end
    for (int k = 0; k < N; k++) res[k] = cur[k][WIDTH-1:0];
  endtask

  task automatic do_start(input logic [WIDTH-1:0] tol_v, input logic [ITER_W-1:0] mi);
    @(negedge clk);
    start = 1'b1;
    tol = tol_v;
    max_iter = mi;
    @(negedge clk);
    start = 1'b0;
    tol = $urandom;
    max_iter = ITER_W'($urandom);
  endtask

  task automatic do_load(input grid_t g, input bit gaps);
    int idx = 0;
    int cyc = 0;
    while (idx < N && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = g[idx];
      if (in_valid && in_ready) idx++;
    end
  endtask

  // Drives one complete solve and records what the DUT produced; no judging here.
  task automatic run_solve(input grid_t g, input logic [WIDTH-1:0] tol_v,
                           input logic [ITER_W-1:0] mi, input int mode,
                           input bit gaps, input bit start_on_done);
    int cyc = 0;
    bit prev_stall = 0;
    bit tog = 0;
    logic [WIDTH-1:0] prev_data = '0;
    do_start(tol_v, mi);
    do_load(g, gaps);
    got_lat = 0;
    got_beats = 0;
    got_dones = 0;
    got_stall_ok = 1;
    got_last_ok = 1;
    got_iter = -1;
    got_conv = 0;
    got_busy_after = 1;
    for (int k = 0; k < N; k++) got[k] = '0;
    while (got_lat < 5000) begin
      @(negedge clk);
      got_lat++;
      in_valid  = $urandom_range(0, 1);
      in_data   = $urandom;
      out_ready = 1'b0;
      start     = ($urandom_range(0, 3) == 0);
      if (done) got_dones++;
      if (out_valid) break;
    end
    in_valid = 1'b0;
    start = 1'b0;
    while (got_beats < N && cyc < 2000) begin
      tog = ~tog;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      if (done) got_dones++;
      if (prev_stall && out_data !== prev_data) got_stall_ok = 0;
      prev_stall = 0;
      if (out_valid) begin
        if (out_ready) begin
          got[got_beats] = out_data;
          if (out_last !== (got_beats == N - 1)) got_last_ok = 0;
          got_beats++;
        end else begin
          prev_stall = 1;
          prev_data = out_data;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (done) got_dones++;
      if (k == 0) begin
        got_iter = int'(iter_count);
        got_conv = converged;
        if (start_on_done) start = 1'b1;
      end
      if (k == 1) begin
        start = 1'b0;
        got_busy_after = busy;
      end
      @(negedge clk);
    end
  endtask

  function automatic grid_t fill(input logic [WIDTH-1:0] bnd, input logic [WIDTH-1:0] inner);
    grid_t g;
    for (int i = 0; i < ROWS + 2; i++)
      for (int j = 0; j < COLS + 2; j++)
        g[i*STRIDE+j] = (i == 0 || j == 0 || i == ROWS + 1 || j == COLS + 1) ? bnd : inner;
    return g;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if ({in_ready, out_valid, out_last, busy, done, converged} !== 6'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got %b expected 000000",
               {in_ready, out_valid, out_last, busy, done, converged});
    end
    n_cmp++;
    if (iter_count !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_iter: got %0d expected 0", iter_count);
    end
    n_cmp++;
    if (out_data !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_out_data: got %h expected 0", out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_uniform(input string tag);
    grid_t g;
    g = fill(32'h0001_0000, 32'h0001_0000);
    run_solve(g, '0, 16'd10, 0, 0, 0);
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (got[k] !== 32'h0001_0000) begin
        n_fail++;
        $display("[TB] FAIL %s_word%0d: got %h expected 00010000", tag, k, got[k]);
      end
    end
    n_cmp++;
    if (got_iter !== 1 || got_conv !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL %s_status: got iter %0d conv %0b expected iter 1 conv 1", tag, got_iter, got_conv);
    end
    n_cmp++;
    if (got_dones !== 1 || got_beats !== N) begin
      n_fail++;
      $display("[TB] FAIL %s_done: got %0d pulses %0d beats expected 1 and %0d", tag, got_dones, got_beats, N);
    end
    n_cmp++;
    if (got_lat !== 1 + (ROWS * COLS + 1)) begin
      n_fail++;
      $display("[TB] FAIL %s_latency: got %0d expected %0d", tag, got_lat, 1 + ROWS * COLS + 1);
    end
  endtask

  task automatic test_impulse;
    grid_t g, exp_g;
    g = fill('0, '0);
    g[1*STRIDE+1] = 32'h0004_0000;
    exp_g = fill('0, '0);
    exp_g[1*STRIDE+2] = 32'h0001_0000;
    exp_g[2*STRIDE+1] = 32'h0001_0000;
    run_solve(g, '0, 16'd1, 0, 1, 0);
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (got[k] !== exp_g[k]) begin
        n_fail++;
        $display("[TB] FAIL impulse_word%0d: got %h expected %h", k, got[k], exp_g[k]);
      end
    end
    n_cmp++;
    if (got_iter !== 1 || got_conv !== 1'b0 || got_dones !== 1) begin
      n_fail++;
      $display("[TB] FAIL impulse_status: got iter %0d conv %0b done %0d expected 1 0 1", got_iter, got_conv, got_dones);
    end
  endtask

  task automatic test_neg_boundary;
    grid_t g, exp_g;
    int exp_it;
    bit exp_cv;
    g = fill(32'hFFFF_0000, '0);
    model(g, '0, 1, exp_g, exp_it, exp_cv);
    run_solve(g, '0, 16'd1, 0, 0, 0);
    n_cmp++;
    if (got[1*STRIDE+1] !== 32'hFFFF_8000) begin
      n_fail++;
      $display("[TB] FAIL negbnd_corner: got %h expected ffff8000", got[1*STRIDE+1]);
    end
    n_cmp++;
    if (got[1*STRIDE+2] !== 32'hFFFF_C000) begin
      n_fail++;
      $display("[TB] FAIL negbnd_edge: got %h expected ffffc000", got[1*STRIDE+2]);
    end
    n_cmp++;
    if (got[2*STRIDE+2] !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL negbnd_center: got %h expected 0", got[2*STRIDE+2]);
    end
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (got[k] !== exp_g[k]) begin
        n_fail++;
        $display("[TB] FAIL negbnd_word%0d: got %h expected %h", k, got[k], exp_g[k]);
      end
    end
    n_cmp++;
    if (got_conv !== 1'b0 || got_iter !== 1) begin
      n_fail++;
      $display("[TB] FAIL negbnd_status: got iter %0d conv %0b expected 1 0", got_iter, got_conv);
    end
  endtask

  task automatic test_zero_iter;
    grid_t g;
    for (int k = 0; k < N; k++) g[k] = $urandom;
    run_solve(g, $urandom, 16'd0, 0, 1, 0);
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (got[k] !== g[k]) begin
        n_fail++;
        $display("[TB] FAIL zero_iter_word%0d: got %h expected %h", k, got[k], g[k]);
      end
    end
    n_cmp++;
    if (got_iter !== 0 || got_conv !== 1'b0 || got_lat !== 1) begin
      n_fail++;
      $display("[TB] FAIL zero_iter_status: got iter %0d conv %0b lat %0d expected 0 0 1", got_iter, got_conv, got_lat);
    end
  endtask

  task automatic test_backpressure;
    grid_t g, exp_g;
    int exp_it;
    bit exp_cv;
    for (int k = 0; k < N; k++) g[k] = $urandom_range(0, 32'h000F_FFFF);
    model(g, '0, 3, exp_g, exp_it, exp_cv);
    run_solve(g, '0, 16'd3, 1, 1, 0);
    n_cmp++;
    if (got_stall_ok !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bp_stable: got data change under stall expected held data");
    end
    n_cmp++;
    if (got_beats !== N || got_last_ok !== 1'b1 || got_dones !== 1) begin
      n_fail++;
      $display("[TB] FAIL bp_framing: got beats %0d last_ok %0b dones %0d expected %0d 1 1", got_beats, got_last_ok, got_dones, N);
    end
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (got[k] !== exp_g[k]) begin
        n_fail++;
        $display("[TB] FAIL bp_word%0d: got %h expected %h", k, got[k], exp_g[k]);
      end
    end
  endtask

  task automatic test_reset_mid_sweep;
    grid_t g;
    g = fill(32'h0001_0000, 32'h0001_0000);
    do_start('0, 16'd10);
    do_load(g, 0);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midsweep_busy_before: got %b expected 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, out_valid, in_ready} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL midsweep_abort: got %b expected 000", {busy, out_valid, in_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_uniform("rerun");
  endtask

  task automatic test_random;
    grid_t g, exp_g;
    int exp_it, mi, kind;
    bit exp_cv;
    logic [WIDTH-1:0] t, cval;
    for (int run = 0; run < 6; run++) begin
      kind = $urandom_range(0, 2);
      cval = $urandom;
      for (int k = 0; k < N; k++)
        g[k] = (kind == 0) ? $urandom : (kind == 1) ? cval : $urandom_range(0, 32'h0003_FFFF);
      case ($urandom_range(0, 2))
        0:       t = '0;
        1:       t = $urandom_range(0, 32'h0010_0000);
        default: t = 32'hFFFF_FFFF;
      endcase
      mi = $urandom_range(1, 6);
      model(g, t, mi, exp_g, exp_it, exp_cv);
      run_solve(g, t, ITER_W'(mi), 2, 1, 0);
      for (int k = 0; k < N; k++) begin
        n_cmp++;
        if (got[k] !== exp_g[k]) begin
          n_fail++;
          $display("[TB] FAIL rand%0d_word%0d: got %h expected %h", run, k, got[k], exp_g[k]);
        end
      end
      n_cmp++;
      if (got_iter !== exp_it || got_conv !== exp_cv || got_dones !== 1) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_status: got iter %0d conv %0b dones %0d expected %0d %0b 1",
                 run, got_iter, got_conv, got_dones, exp_it, exp_cv);
      end
      n_cmp++;
      if (got_lat !== 1 + exp_it * (ROWS * COLS + 1)) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", run, got_lat, 1 + exp_it * (ROWS * COLS + 1));
      end
    end
  endtask

  task automatic test_back_to_back;
    grid_t g, exp_g;
    int exp_it;
    bit exp_cv;
    g = fill(32'h0002_0000, '0);
    run_solve(g, '0, 16'd2, 0, 0, 1);
    n_cmp++;
    if (got_busy_after !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_start_on_done: got busy %b expected 0", got_busy_after);
    end
    for (int k = 0; k < N; k++) g[k] = $urandom_range(0, 32'h0007_FFFF);
    model(g, 32'h0000_8000, 4, exp_g, exp_it, exp_cv);
    run_solve(g, 32'h0000_8000, 16'd4, 0, 0, 0);
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (got[k] !== exp_g[k]) begin
        n_fail++;
        $display("[TB] FAIL b2b_word%0d: got %h expected %h", k, got[k], exp_g[k]);
      end
    end
    n_cmp++;
    if (got_iter !== exp_it || got_conv !== exp_cv) begin
      n_fail++;
      $display("[TB] FAIL b2b_status: got iter %0d conv %0b expected %0d %0b", got_iter, got_conv, exp_it, exp_cv);
    end
  endtask

  initial begin
    test_reset();
    test_uniform("uniform");
    test_impulse();
    test_neg_boundary();
    test_zero_iter();
    test_backpressure();
    test_reset_mid_sweep();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/jacobi_5pt_stream.md
Name: jacobi_5pt_stream

Overview:
Parametrised 5-point Jacobi Laplace solver for a rectangular ROWS x COLS interior grid with a fixed one-cell boundary ring, in signed Q(WIDTH-FRAC).FRAC fixed point.
- Grid is streamed in and out over valid/ready handshakes; there is no flat grid bus.
- Supports a run-time tolerance and an iteration cap, and reports iteration count and convergence status.
- Sits between the host DMA streamer and the result buffer, as the successor to the square, flat-bus Jacobi core.

Parameters:
ROWS, 4, interior rows (>=1)
COLS, 4, interior columns (>=1)
WIDTH, 32, data word width
FRAC, 16, fractional bits
ITER_W, 16, iteration counter width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a solve; sampled only in IDLE
tol  in  WIDTH  unsigned max-abs residual threshold; sampled at start
max_iter  in  ITER_W  sweep cap; sampled at start
in_valid  in  1  input word valid
in_ready  out  1  high only in LOAD
in_data  in  WIDTH  grid word, row-major, (ROWS+2)*(COLS+2) words including boundary
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts
out_data  out  WIDTH  grid word, row-major, full (ROWS+2)*(COLS+2) grid
out_last  out  1  high with the final output word
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last output beat is accepted
converged  out  1  valid from done until next start
iter_count  out  ITER_W  sweeps performed; valid from done until next start

Behaviour:
- Reset (async, rst_n low): state=IDLE. All outputs are 0 (in_ready, out_valid, out_last, busy, done, converged, iter_count, out_data). Grid buffers are not reset.
- States and transitions: IDLE -> LOAD -> SWEEP -> CHECK -> (SWEEP | UNLOAD) -> IDLE.
- IDLE: on start, latch tol and max_iter, clear iter_count and converged, go to LOAD. Start is ignored in any other state.
- LOAD: one word per cycle when in_valid && in_ready. Words are written to both ping-pong buffers A and B, so the boundary exists in both. After N=(ROWS+2)*(COLS+2) beats:
  - max_iter==0: go to UNLOAD, converged=0.
  - otherwise: go to SWEEP, source=A.
- SWEEP: one interior point per cycle, row-major, ROWS*COLS cycles.
  - s = sum of the 4 neighbours, sign-extended to WIDTH+2 bits.
  - dst[i][j] = s >>> 2 (arithmetic shift, truncate toward -inf), truncated to WIDTH bits. No overflow is possible.
  - r = 4*u[i][j] - s, computed in WIDTH+3 bits on the source buffer.
  - maxres = max(maxres, |r|). maxres clears on entry to SWEEP.
- CHECK: 1 cycle. iter_count++. Swap the buffers (dst becomes source). Then:
  - maxres <= tol: converged=1, go to UNLOAD.
  - else if iter_count (after increment) == max_iter: converged=0, go to UNLOAD.
  - else: go to SWEEP.
- Sweep latency: ROWS*COLS+1 cycles per iteration.
- UNLOAD: streams the current source buffer, which is the most recently written one.
  - out_valid is held, and out_data and out_last are held stable, until out_ready.
  - out_last is high on beat N only.
  - After beat N is accepted: done=1 for one cycle, go to IDLE.
- Boundary words are passed through unchanged.
- tol is unsigned. tol=0 requires an exact zero residual.
- in_valid outside LOAD is ignored. out_ready outside UNLOAD is ignored.
- A start pulse that coincides with done, or arrives during busy, is dropped.
- Reset during any state aborts immediately. After reset release, a new start runs cleanly.

Optional Feature:
Macro JACOBI_DAMP_EN.
- Defined: adds input omega [WIDTH-1:0] (Q format, sampled at start). SWEEP writes dst = u + ((avg - u)*omega >>> FRAC), where avg = s>>>2. The product is formed at 2*WIDTH bits, and the result saturates to the signed WIDTH range. Sweep latency grows by one pipeline stage: ROWS*COLS+2 cycles per iteration.
- Undefined: the omega port is absent and plain Jacobi (equivalent to omega=1.0) is used.

Test Plan:
1. Default params, all 36 words=0x00010000, tol=0, max_iter=10 -> iter_count=1, converged=1, output identical to input, done once.
2. Boundary 0, interior 0 except u[1][1]=0x00040000, tol=0, max_iter=1 -> out u[1][1]=0, u[1][2]=0x00010000, u[2][1]=0x00010000, all other interior 0, converged=0, iter_count=1.
3. Boundary all 0xFFFF0000, interior 0, max_iter=1 -> u[1][1]=0xFFFF8000, u[1][2]=0xFFFFC000, u[2][2]=0, converged=0.
4. max_iter=0, any grid -> 36 words echoed unchanged, iter_count=0, converged=0.
5. out_ready toggled every other cycle during UNLOAD -> out_data stable while stalled, exactly 36 beats, out_last only on beat 36, single done pulse.
6. rst_n pulsed low mid-SWEEP -> busy, out_valid, in_ready go to 0 immediately; rerun of test 1 then passes.
